// File: rtl/pokey_pkg.sv
// ---------------------------------------------------------------------------
// pokey_pkg
// Shared constants and helpers for the POKEY audio frequency divider.
//   AUDF_W     : width of one AUDF register / channel byte
//   FAST_OFF8  : reload offset added to channel A when it runs at clk rate
//   FAST_OFF16 : reload offset added to the joined 16-bit counter when fast
//   CNT_A_W    : channel A counter width (one extra bit so AUDF+3 never wraps)
//   CNT_B_W    : channel B counter width
//   JOIN_W     : width of the joined B:A counter
// ---------------------------------------------------------------------------
package pokey_pkg;

  localparam int AUDF_W     = 8;
  localparam int FAST_OFF8  = 3;
  localparam int FAST_OFF16 = 6;
  localparam int CNT_A_W    = AUDF_W + 1;
  localparam int CNT_B_W    = AUDF_W;
  localparam int JOIN_W     = 2 * AUDF_W;

  typedef logic [AUDF_W-1:0] audf_t;
  typedef logic [JOIN_W-1:0] join_t;

  // Adds the fast-clock offset to a 16-bit AUDF pair, clamping at all-ones
  // instead of wrapping so a huge AUDF never turns into a tiny period.
  function automatic join_t sat_add16(input join_t base, input logic add_off);
    logic [JOIN_W:0] sum;
    sum = {1'b0, base} + (add_off ? (JOIN_W+1)'(FAST_OFF16) : '0);
    return sum[JOIN_W] ? '1 : sum[JOIN_W-1:0];
  endfunction

endpackage

// File: rtl/pokey_div_chan.sv
// ---------------------------------------------------------------------------
// pokey_div_chan
// One down-counting divider channel. State changes on the falling clock edge.
// Ports:
//   clk_i      : system clock (falling edge active)
//   rst_ni     : asynchronous active-low reset
//   en_i       : count enable for this cycle
//   force_i    : load reload_i unconditionally, no tick (STIMER)
//   tick_en_i  : allow an underflow to raise tick_o
//   reload_i   : value loaded on underflow or force
//   cnt_o      : current counter value
//   zero_o     : counter currently holds zero (used for chaining)
//   tick_o     : registered one-cycle underflow pulse
// ---------------------------------------------------------------------------
module pokey_div_chan
  import pokey_pkg::*;
#(
  parameter int W = CNT_B_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         force_i,
  input  logic         tick_en_i,
  input  logic [W-1:0] reload_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  assign zero_o = (cnt_q == '0);
  assign cnt_o  = cnt_q;
  assign tick_o = tick_q;

  // Force beats the enable, so a STIMER landing on an underflow cycle
  // reloads silently instead of ticking.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (force_i) begin
      cnt_d = reload_i;
    end else if (en_i) begin
      if (zero_o) begin
        cnt_d  = reload_i;
        tick_d = tick_en_i;
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  // Falling-edge state to line up with the cell2pr-style downstream flops.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/pokey_freq_div.sv
// ---------------------------------------------------------------------------
// pokey_freq_div
// Dual-channel POKEY audio frequency divider. Two AUDF-driven down-counters
// emit one-clock underflow ticks for the polynomial/distortion stage.
// Optional 16-bit join mode is compiled in with `define POKEY_JOIN16_EN;
// without it the join_i port is ignored and channels are always independent.
// Ports:
//   clk_i             : system clock, all state updates on the falling edge
//   rst_ni            : asynchronous active-low reset
//   base_tick_i       : prescaler enable (64 kHz / 15 kHz)
//   fast_a_i          : channel A counts every clk instead of base_tick_i
//   audf_a_i/audf_b_i : AUDF write data for channels A and B
//   wr_a_i/wr_b_i     : AUDF write strobes
//   stimer_i          : reload both counters, no tick
//   join_i            : 16-bit link mode request (B high byte, A low byte)
//   tick_a_o/tick_b_o : registered underflow pulses
//   cnt_a_o/cnt_b_o   : current counter values (debug)
// ---------------------------------------------------------------------------
module pokey_freq_div
  import pokey_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               base_tick_i,
  input  logic               fast_a_i,
  input  logic [AUDF_W-1:0]  audf_a_i,
  input  logic [AUDF_W-1:0]  audf_b_i,
  input  logic               wr_a_i,
  input  logic               wr_b_i,
  input  logic               stimer_i,
  input  logic               join_i,
  output logic               tick_a_o,
  output logic               tick_b_o,
  output logic [CNT_A_W-1:0] cnt_a_o,
  output logic [CNT_B_W-1:0] cnt_b_o
);

  audf_t audf_a_q, audf_a_d;
  audf_t audf_b_q, audf_b_d;

  logic               en_a, en_b;
  logic [CNT_A_W-1:0] fast_off_a;
  logic [CNT_A_W-1:0] rel_a_ind;

  logic               cha_en, cha_force, cha_tick_en, cha_zero;
  logic [CNT_A_W-1:0] cha_reload;
  logic               chb_en, chb_force, chb_tick_en, chb_zero;
  logic [CNT_B_W-1:0] chb_reload;

  // The next-state AUDF value doubles as the reload source, which gives the
  // write-bypass for a reload in the same cycle as the strobe.
  always_comb begin
    audf_a_d = wr_a_i ? audf_a_i : audf_a_q;
    audf_b_d = wr_b_i ? audf_b_i : audf_b_q;
  end

  // AUDF holding registers; a write alone never touches the counters.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      audf_a_q <= '0;
      audf_b_q <= '0;
    end else begin
      audf_a_q <= audf_a_d;
      audf_b_q <= audf_b_d;
    end
  end

  assign en_a       = fast_a_i | base_tick_i;
  assign en_b       = base_tick_i;
  assign fast_off_a = fast_a_i ? CNT_A_W'(FAST_OFF8) : '0;
  assign rel_a_ind  = {1'b0, audf_a_d} + fast_off_a;

`ifdef POKEY_JOIN16_EN
  logic  join_q, join_d;
  logic  a_uf, full_uf, boundary;
  join_t rel16;

  // A mode change is only honoured at a reload boundary of the mode that is
  // currently active, so a running count is never reinterpreted.
  assign a_uf     = en_a & cha_zero;
  assign full_uf  = a_uf & chb_zero;
  assign boundary = stimer_i | (join_q ? full_uf : a_uf);
  assign join_d   = boundary ? join_i : join_q;
  assign rel16    = sat_add16({audf_b_d, audf_a_d}, fast_a_i);

  // In join mode A's own reload is replaced by a wrap to 0xFF so the low
  // byte borrows into B; a real reload only happens on full 16-bit underflow.
  // Entering join from an A reload also forces B onto the high byte.
  always_comb begin
    cha_en      = en_a;
    cha_force   = stimer_i;
    cha_tick_en = ~join_q;
    if (join_q && !boundary) begin
      cha_reload = {1'b0, {AUDF_W{1'b1}}};
    end else if (join_d) begin
      cha_reload = {1'b0, rel16[AUDF_W-1:0]};
    end else begin
      cha_reload = rel_a_ind;
    end
    chb_en      = join_q ? a_uf : en_b;
    chb_force   = stimer_i | (~join_q & join_d);
    chb_tick_en = 1'b1;
    chb_reload  = join_d ? rel16[JOIN_W-1:AUDF_W] : audf_b_d;
  end

  // Active link mode, latched at reload boundaries.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      join_q <= 1'b0;
    end else begin
      join_q <= join_d;
    end
  end
`else
  logic unused_join;

  assign cha_en      = en_a;
  assign cha_force   = stimer_i;
  assign cha_tick_en = 1'b1;
  assign cha_reload  = rel_a_ind;
  assign chb_en      = en_b;
  assign chb_force   = stimer_i;
  assign chb_tick_en = 1'b1;
  assign chb_reload  = audf_b_d;
  assign unused_join = ^{join_i, cha_zero, chb_zero};
`endif

  pokey_div_chan #(.W(CNT_A_W)) u_chan_a (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (cha_en),
    .force_i   (cha_force),
    .tick_en_i (cha_tick_en),
    .reload_i  (cha_reload),
    .cnt_o     (cnt_a_o),
    .zero_o    (cha_zero),
    .tick_o    (tick_a_o)
  );

  pokey_div_chan #(.W(CNT_B_W)) u_chan_b (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (chb_en),
    .force_i   (chb_force),
    .tick_en_i (chb_tick_en),
    .reload_i  (chb_reload),
    .cnt_o     (cnt_b_o),
    .zero_o    (chb_zero),
    .tick_o    (tick_b_o)
  );

endmodule
